scrambler_ctrl: RTL and testbench



---
 rtl/scrambler_ctrl_if.sv | 38 +++
 rtl/scrambler_ctrl.sv | 140 ++++++++++++++
 tb/tb_scrambler_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scrambler_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : scrambler_ctrl_if
// Desc     : Symbol-in, engine-drive and symbol-out bundle of scrambler_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface scrambler_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] sym_i;
    logic                  sym_k_i;
    logic                  sym_valid_i;
    logic                  sym_ready_o;
    logic                  scr_disable_i;
    logic                  eng_load_o;
    logic [DATA_WIDTH-1:0] eng_data_o;
    logic                  eng_shift_o;
    logic                  eng_seed_o;
    logic                  eng_bit_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_k_o;
    logic                  out_valid_o;
    logic                  out_ready_i;

    // slave is the controller; master is the surrounding lane mux/engine/encoder
    modport slave (
        input  sym_i, sym_k_i, sym_valid_i, scr_disable_i, eng_bit_i, out_ready_i,
        output sym_ready_o, eng_load_o, eng_data_o, eng_shift_o, eng_seed_o,
               out_data_o, out_k_o, out_valid_o
    );

    modport master (
        output sym_i, sym_k_i, sym_valid_i, scr_disable_i, eng_bit_i, out_ready_i,
        input  sym_ready_o, eng_load_o, eng_data_o, eng_shift_o, eng_seed_o,
               out_data_o, out_k_o, out_valid_o
    );
endinterface
`default_nettype wire

// File: rtl/scrambler_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scrambler_ctrl
// Desc     : Per-lane sequencer for the bit-serial scrambler engine. Optional
//            statistics counters enabled by `define SCRAMBLER_CTRL_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module scrambler_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] COM_SYMBOL = 8'hBC,
    parameter logic [DATA_WIDTH-1:0] SKP_SYMBOL = 8'h1C
) (
    input  logic            clk_i,
    input  logic            rst_i,
    scrambler_ctrl_if.slave bus
`ifdef SCRAMBLER_CTRL_STATS_EN
    ,
    output logic [15:0]     stat_com_cnt_o,
    output logic [15:0]     stat_scr_cnt_o
`endif
);

    localparam int                 c_CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_k;
    logic                  r_bypass;
    logic                  r_seed;

    logic                  w_accept;
    logic                  w_is_com;
    logic                  w_is_skp;
    logic                  w_last;

    // Gated by rst_i so nothing leaks onto the engine while reset is held.
    assign w_accept = (r_state == S_IDLE) && bus.sym_valid_i && !rst_i;
    assign w_is_com = bus.sym_k_i && (bus.sym_i == COM_SYMBOL);
    assign w_is_skp = bus.sym_k_i && (bus.sym_i == SKP_SYMBOL);
    assign w_last   = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        bus.sym_ready_o = 1'b0;
        bus.eng_load_o  = 1'b0;
        bus.eng_data_o  = '0;
        bus.eng_shift_o = 1'b0;
        bus.eng_seed_o  = r_seed;
        bus.out_valid_o = 1'b0;
        bus.out_data_o  = r_data;
        bus.out_k_o     = r_k;
        case (r_state)
            S_IDLE: begin
                bus.sym_ready_o = 1'b1;
                if (w_accept) begin
                    bus.eng_load_o = 1'b1;
                    bus.eng_data_o = bus.sym_i;
                    w_state_nxt    = (w_is_com || w_is_skp) ? S_OUT : S_SHIFT;
                end
            end
            S_SHIFT: begin
                bus.eng_shift_o = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                bus.out_valid_o = 1'b1;
                if (bus.out_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_data   <= '0;
            r_k      <= 1'b0;
            r_bypass <= 1'b0;
            r_seed   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_seed  <= w_accept && w_is_com;
            if (w_accept) begin
                r_data   <= bus.sym_i;
                r_k      <= bus.sym_k_i;
                // Non-COM/SKP K characters and disabled data still advance the LFSR
                r_bypass <= bus.sym_k_i || bus.scr_disable_i;
            end
            if (r_state == S_SHIFT) begin
                if (!r_bypass) begin
                    r_data[r_cnt] <= bus.eng_bit_i;
                end
                r_cnt <= w_last ? '0 : r_cnt + c_CNT_W'(1);
            end
        end
    end

`ifdef SCRAMBLER_CTRL_STATS_EN
    logic [15:0] r_com_cnt;
    logic [15:0] r_scr_cnt;
    logic        w_scrambled;

    assign w_scrambled = w_accept && !bus.sym_k_i && !bus.scr_disable_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_com_cnt <= '0;
            r_scr_cnt <= '0;
        end else begin
            if (w_accept && w_is_com && (r_com_cnt != 16'hFFFF)) begin
                r_com_cnt <= r_com_cnt + 16'd1;
            end
            if (w_scrambled && (r_scr_cnt != 16'hFFFF)) begin
                r_scr_cnt <= r_scr_cnt + 16'd1;
            end
        end
    end

    assign stat_com_cnt_o = r_com_cnt;
    assign stat_scr_cnt_o = r_scr_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scrambler_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scrambler_ctrl
// Desc     : Self-checking bench for scrambler_ctrl with a behavioural engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scrambler_ctrl;

    logic clk;
    logic rst_i;
    int   n_tests = 0;
    int   n_fail  = 0;

    bit   stream [4096];
    int   eptr;
    logic [2:0] eidx;
    logic [7:0] eword;
    int   mptr;

    scrambler_ctrl_if #(.DATA_WIDTH(8)) bus ();

`ifdef SCRAMBLER_CTRL_STATS_EN
    logic [15:0] stat_com;
    logic [15:0] stat_scr;
`endif

    scrambler_ctrl dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
`ifdef SCRAMBLER_CTRL_STATS_EN
        ,
        .stat_com_cnt_o (stat_com),
        .stat_scr_cnt_o (stat_scr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine: LFSR bit stream indexed by eptr, data word shifted out LSB first
    assign bus.eng_bit_i = eword[eidx] ^ stream[eptr];

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            eptr  <= 0;
            eidx  <= 3'd0;
            eword <= 8'h00;
        end else begin
            if (bus.eng_seed_o) begin
                eptr <= 0;
            end else if (bus.eng_shift_o) begin
                eptr <= (eptr + 1) % 4096;
                eidx <= eidx + 3'd1;
            end
            if (bus.eng_load_o) begin
                eword <= bus.eng_data_o;
                eidx  <= 3'd0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_i && (bus.eng_load_o || bus.eng_shift_o || bus.eng_seed_o)) begin
            n_tests++;
            if ((int'(bus.eng_load_o) + int'(bus.eng_shift_o) + int'(bus.eng_seed_o)) > 1) begin
                n_fail++;
                $display("FAIL eng_exclusive: load=%b shift=%b seed=%b, required at most one", bus.eng_load_o, bus.eng_shift_o, bus.eng_seed_o);
            end
        end
    end

    task automatic model_sym(input logic [7:0] d, input bit k, input bit dis,
                             output logic [7:0] ed, output int elat, output int esh, output int eseed);
        ed = d;
        eseed = 0;
        if (k && d == 8'hBC) begin
            elat = 1; esh = 0; eseed = 1; mptr = 0;
        end else if (k && d == 8'h1C) begin
            elat = 1; esh = 0;
        end else begin
            elat = 9; esh = 8;
            if (!k && !dis)
                for (int i = 0; i < 8; i++) ed[i] = d[i] ^ stream[(mptr + i) % 4096];
            mptr = (mptr + 8) % 4096;
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #3;
        rst_i = 1'b1; bus.sym_valid_i = 1'b0; bus.out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_i = 1'b0;
        mptr = 0;
        @(posedge clk); #1;
    endtask

    // Sends one symbol, waits for out_valid_o (bounded), then handshakes it out.
    task automatic run_sym(input logic [7:0] d, input bit k, input bit dis, input int rdy_delay,
                           output logic [7:0] od, output bit ok, output bit acc,
                           output int lat, output int nsh, output int nseed, output int seed_at);
        @(posedge clk); #1;
        bus.sym_i = d; bus.sym_k_i = k; bus.scr_disable_i = dis;
        bus.sym_valid_i = 1'b1; bus.out_ready_i = 1'b0;
        @(negedge clk);
        acc = bus.sym_ready_o && bus.eng_load_o && (bus.eng_data_o == d);
        @(posedge clk); #1;
        bus.sym_valid_i = 1'b0;
        bus.sym_i = 8'($urandom); bus.sym_k_i = 1'($urandom); bus.scr_disable_i = 1'($urandom);
        lat = 0; nsh = 0; nseed = 0; seed_at = -1;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (bus.eng_shift_o) nsh++;
            if (bus.eng_seed_o) begin nseed++; seed_at = c; end
            if (bus.out_valid_o) lat = c;
        end
        od = bus.out_data_o; ok = bus.out_k_o;
        for (int c = 0; c < rdy_delay; c++) begin
            @(negedge clk);
            if (bus.eng_shift_o) nsh++;
            if (bus.eng_seed_o) nseed++;
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        bus.sym_i = 8'h55; bus.sym_k_i = 1'b0; bus.sym_valid_i = 1'b1;
        #2 rst_i = 1'b1;
        #1;
        n_tests++; if (bus.sym_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, required 1", bus.sym_ready_o); end
        n_tests++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", bus.out_valid_o); end
        n_tests++; if (bus.eng_load_o !== 1'b0) begin n_fail++; $display("FAIL rst_load: got %b, required 0", bus.eng_load_o); end
        n_tests++; if (bus.eng_shift_o !== 1'b0) begin n_fail++; $display("FAIL rst_shift: got %b, required 0", bus.eng_shift_o); end
        n_tests++; if (bus.eng_seed_o !== 1'b0) begin n_fail++; $display("FAIL rst_seed: got %b, required 0", bus.eng_seed_o); end
        n_tests++; if (bus.eng_data_o !== 8'h00) begin n_fail++; $display("FAIL rst_eng_data: got %h, required 00", bus.eng_data_o); end
        n_tests++; if (bus.out_data_o !== 8'h00) begin n_fail++; $display("FAIL rst_out_data: got %h, required 00", bus.out_data_o); end
        n_tests++; if (bus.out_k_o !== 1'b0) begin n_fail++; $display("FAIL rst_out_k: got %b, required 0", bus.out_k_o); end
        bus.sym_valid_i = 1'b0;
        @(posedge clk); #3 rst_i = 1'b0;
        mptr = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_scramble();
        logic [7:0] od; bit ok, acc; int lat, nsh, nseed, sat;
        stream[0] = 1; stream[1] = 0; stream[2] = 1; stream[3] = 1;
        stream[4] = 0; stream[5] = 0; stream[6] = 0; stream[7] = 0;
        run_sym(8'h00, 1'b0, 1'b0, 0, od, ok, acc, lat, nsh, nseed, sat);
        mptr = 8;
        n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL scr_accept: got %b, required 1", acc); end
        n_tests++; if (od !== 8'h0D) begin n_fail++; $display("FAIL scr_data: got %h, required 0d", od); end
        n_tests++; if (ok !== 1'b0) begin n_fail++; $display("FAIL scr_k: got %b, required 0", ok); end
        n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL scr_latency: got %0d, required 9", lat); end
        n_tests++; if (nsh !== 8) begin n_fail++; $display("FAIL scr_shifts: got %0d, required 8", nsh); end
    endtask

    task automatic test_com();
        logic [7:0] od, ed; bit ok, acc; int lat, nsh, nseed, sat, elat, esh, eseed;
        model_sym(8'hBC, 1'b1, 1'b0, ed, elat, esh, eseed);
        run_sym(8'hBC, 1'b1, 1'b0, 3, od, ok, acc, lat, nsh, nseed, sat);
        n_tests++; if (od !== 8'hBC) begin n_fail++; $display("FAIL com_data: got %h, required bc", od); end
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL com_k: got %b, required 1", ok); end
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL com_latency: got %0d, required 1", lat); end
        n_tests++; if (nsh !== 0) begin n_fail++; $display("FAIL com_shifts: got %0d, required 0", nsh); end
        n_tests++; if (nseed !== 1) begin n_fail++; $display("FAIL com_seed_count: got %0d, required 1", nseed); end
        n_tests++; if (sat !== 1) begin n_fail++; $display("FAIL com_seed_cycle: got %0d, required 1", sat); end
    endtask

    task automatic test_skp_then_data();
        logic [7:0] od, ed; bit ok, acc; int lat, nsh, nseed, sat, elat, esh, eseed;
        model_sym(8'h1C, 1'b1, 1'b0, ed, elat, esh, eseed);
        run_sym(8'h1C, 1'b1, 1'b0, 1, od, ok, acc, lat, nsh, nseed, sat);
        n_tests++; if (od !== 8'h1C) begin n_fail++; $display("FAIL skp_data: got %h, required 1c", od); end
        n_tests++; if (nsh !== 0 || nseed !== 0) begin n_fail++; $display("FAIL skp_engine: got shifts=%0d seeds=%0d, required 0/0", nsh, nseed); end
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL skp_latency: got %0d, required 1", lat); end
        model_sym(8'hFF, 1'b0, 1'b0, ed, elat, esh, eseed);
        run_sym(8'hFF, 1'b0, 1'b0, 0, od, ok, acc, lat, nsh, nseed, sat);
        n_tests++; if (od !== ed) begin n_fail++; $display("FAIL skp_next_data: got %h, required %h", od, ed); end
        n_tests++; if (nsh !== 8) begin n_fail++; $display("FAIL skp_next_shifts: got %0d, required 8", nsh); end
    endtask

    task automatic test_bypass();
        logic [7:0] od, ed; bit ok, acc; int lat, nsh, nseed, sat, elat, esh, eseed;
        model_sym(8'hA5, 1'b0, 1'b1, ed, elat, esh, eseed);
        run_sym(8'hA5, 1'b0, 1'b1, 0, od, ok, acc, lat, nsh, nseed, sat);
        n_tests++; if (od !== 8'hA5 || ok !== 1'b0) begin n_fail++; $display("FAIL dis_data: got %h k=%b, required a5 k=0", od, ok); end
        n_tests++; if (nsh !== 8 || lat !== 9) begin n_fail++; $display("FAIL dis_shifts: got shifts=%0d lat=%0d, required 8/9", nsh, lat); end
        model_sym(8'hFC, 1'b1, 1'b0, ed, elat, esh, eseed);
        run_sym(8'hFC, 1'b1, 1'b0, 2, od, ok, acc, lat, nsh, nseed, sat);
        n_tests++; if (od !== 8'hFC || ok !== 1'b1) begin n_fail++; $display("FAIL k28_7_data: got %h k=%b, required fc k=1", od, ok); end
        n_tests++; if (nsh !== 8 || lat !== 9) begin n_fail++; $display("FAIL k28_7_shifts: got shifts=%0d lat=%0d, required 8/9", nsh, lat); end
        // LFSR must have advanced 16 bits across the two bypassed symbols
        model_sym(8'h5A, 1'b0, 1'b0, ed, elat, esh, eseed);
        run_sym(8'h5A, 1'b0, 1'b0, 0, od, ok, acc, lat, nsh, nseed, sat);
        n_tests++; if (od !== ed) begin n_fail++; $display("FAIL bypass_advance: got %h, required %h", od, ed); end
    endtask

    task automatic test_random();
        logic [7:0] d, od, ed; bit k, dis, ok, acc; int lat, nsh, nseed, sat, elat, esh, eseed, sel;
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(99));
            dis = ($urandom_range(3) == 0);
            if (sel < 20)      begin d = 8'hBC; k = 1'b1; end
            else if (sel < 35) begin d = 8'h1C; k = 1'b1; end
            else if (sel < 50) begin d = 8'($urandom); k = 1'b1; if (d == 8'hBC || d == 8'h1C) d = 8'hFC; end
            else               begin d = 8'($urandom); k = 1'b0; end
            model_sym(d, k, dis, ed, elat, esh, eseed);
            run_sym(d, k, dis, int'($urandom_range(3)), od, ok, acc, lat, nsh, nseed, sat);
            n_tests++;
            if (od !== ed || ok !== k || lat !== elat || nsh !== esh || nseed !== eseed || acc !== 1'b1) begin
                n_fail++;
                $display("FAIL random[%0d] sym=%h k=%b dis=%b: got data=%h k=%b lat=%0d sh=%0d seed=%0d acc=%b, required data=%h k=%b lat=%0d sh=%0d seed=%0d acc=1",
                         n, d, k, dis, od, ok, lat, nsh, nseed, acc, ed, k, elat, esh, eseed);
            end
        end
    endtask

    task automatic test_back_to_back();
        int loads[$];
        bus.out_ready_i = 1'b1;
        bus.sym_i = 8'h42; bus.sym_k_i = 1'b0; bus.scr_disable_i = 1'b0; bus.sym_valid_i = 1'b1;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            if (bus.eng_load_o) loads.push_back(c);
        end
        n_tests++; if (loads.size() !== 4) begin n_fail++; $display("FAIL b2b_data_count: got %0d accepts, required 4", loads.size()); end
        for (int i = 1; i < loads.size(); i++) begin
            n_tests++; if (loads[i] - loads[i-1] !== 10) begin n_fail++; $display("FAIL b2b_data_gap: got %0d cycles, required 10", loads[i] - loads[i-1]); end
        end
        apply_reset();
        loads.delete();
        bus.out_ready_i = 1'b1;
        bus.sym_i = 8'hBC; bus.sym_k_i = 1'b1; bus.sym_valid_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.eng_load_o) loads.push_back(c);
        end
        n_tests++; if (loads.size() !== 5) begin n_fail++; $display("FAIL b2b_com_count: got %0d accepts, required 5", loads.size()); end
        for (int i = 1; i < loads.size(); i++) begin
            n_tests++; if (loads[i] - loads[i-1] !== 2) begin n_fail++; $display("FAIL b2b_com_gap: got %0d cycles, required 2", loads[i] - loads[i-1]); end
        end
        apply_reset();
    endtask

    task automatic test_backpressure();
        logic [7:0] ed; int elat, esh, eseed, lat;
        model_sym(8'h3C, 1'b0, 1'b0, ed, elat, esh, eseed);
        bus.sym_i = 8'h3C; bus.sym_k_i = 1'b0; bus.scr_disable_i = 1'b0;
        bus.sym_valid_i = 1'b1; bus.out_ready_i = 1'b0;
        @(posedge clk); #1;
        bus.sym_valid_i = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (bus.out_valid_o) lat = c;
        end
        n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL bp_latency: got %0d, required 9", lat); end
        for (int c = 0; c < 20; c++) begin
            bus.sym_valid_i = 1'($urandom);
            @(negedge clk);
            n_tests++;
            if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== ed || bus.sym_ready_o !== 1'b0 ||
                bus.eng_load_o !== 1'b0 || bus.eng_shift_o !== 1'b0 || bus.eng_seed_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b load=%b shift=%b seed=%b, required 1 %h 0 0 0 0",
                         c, bus.out_valid_o, bus.out_data_o, bus.sym_ready_o, bus.eng_load_o, bus.eng_shift_o, bus.eng_seed_o, ed);
            end
        end
        bus.sym_valid_i = 1'b0;
        #1 rst_i = 1'b1;
        #1;
        n_tests++; if (bus.out_valid_o !== 1'b0 || bus.sym_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_reset_in_out: got valid=%b ready=%b, required 0/1", bus.out_valid_o, bus.sym_ready_o); end
        #1 rst_i = 1'b0;
        mptr = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_shift();
        logic [7:0] od, ed; bit ok, acc; int lat, nsh, nseed, sat, elat, esh, eseed, seen;
        bus.sym_i = 8'h77; bus.sym_k_i = 1'b0; bus.scr_disable_i = 1'b0; bus.sym_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.sym_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++; if (bus.eng_shift_o !== 1'b1) begin n_fail++; $display("FAIL mid_shift_active: got %b, required 1", bus.eng_shift_o); end
        rst_i = 1'b1;
        #1;
        n_tests++;
        if (bus.eng_shift_o !== 1'b0 || bus.sym_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.out_data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_shift_reset: got shift=%b ready=%b valid=%b data=%h, required 0 1 0 00",
                     bus.eng_shift_o, bus.sym_ready_o, bus.out_valid_o, bus.out_data_o);
        end
        #2 rst_i = 1'b0;
        mptr = 0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid_o || bus.eng_shift_o) seen++;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL mid_shift_dropped: got %0d active cycles, required 0", seen); end
        model_sym(8'hC3, 1'b0, 1'b0, ed, elat, esh, eseed);
        run_sym(8'hC3, 1'b0, 1'b0, 0, od, ok, acc, lat, nsh, nseed, sat);
        n_tests++; if (od !== ed || lat !== 9 || nsh !== 8) begin n_fail++; $display("FAIL mid_shift_next: got %h lat=%0d sh=%0d, required %h lat=9 sh=8", od, lat, nsh, ed); end
    endtask

`ifdef SCRAMBLER_CTRL_STATS_EN
    task automatic test_stats();
        logic [7:0] od, ed; bit ok, acc; int lat, nsh, nseed, sat, elat, esh, eseed;
        apply_reset();
        n_tests++; if (stat_com !== 16'd0 || stat_scr !== 16'd0) begin n_fail++; $display("FAIL stats_reset: got %0d/%0d, required 0/0", stat_com, stat_scr); end
        run_sym(8'hBC, 1'b1, 1'b0, 0, od, ok, acc, lat, nsh, nseed, sat);
        run_sym(8'h11, 1'b0, 1'b0, 0, od, ok, acc, lat, nsh, nseed, sat);
        run_sym(8'h22, 1'b0, 1'b1, 0, od, ok, acc, lat, nsh, nseed, sat);
        run_sym(8'hF7, 1'b1, 1'b0, 0, od, ok, acc, lat, nsh, nseed, sat);
        run_sym(8'hBC, 1'b1, 1'b0, 0, od, ok, acc, lat, nsh, nseed, sat);
        run_sym(8'h33, 1'b0, 1'b0, 0, od, ok, acc, lat, nsh, nseed, sat);
        @(negedge clk);
        n_tests++; if (stat_com !== 16'd2) begin n_fail++; $display("FAIL stats_com: got %0d, required 2", stat_com); end
        n_tests++; if (stat_scr !== 16'd2) begin n_fail++; $display("FAIL stats_scr: got %0d, required 2", stat_scr); end
        model_sym(8'h00, 1'b0, 1'b0, ed, elat, esh, eseed);
    endtask
`endif

    initial begin
        for (int i = 0; i < 4096; i++) stream[i] = 1'($urandom);
        rst_i = 1'b1;
        bus.sym_i = 8'h00; bus.sym_k_i = 1'b0; bus.sym_valid_i = 1'b0;
        bus.scr_disable_i = 1'b0; bus.out_ready_i = 1'b0;
        mptr = 0;
        repeat (2) @(posedge clk);
        #3 rst_i = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_scramble();
        test_com();
        test_skp_then_data();
        test_bypass();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_shift();
`ifdef SCRAMBLER_CTRL_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
